// File: rtl/serdiv_issue_ctrl_if.sv
// Issue-side, divider-side and writeback-side handshakes of serdiv_issue_ctrl.
// slave = the controller's view; master = the surrounding issue stage, divider and writeback consumer.
interface serdiv_issue_ctrl_if #(
  parameter int WIDTH         = 64,
  parameter int TRANS_ID_BITS = 3
);
  logic                     req_valid;
  logic                     req_ready;
  logic [TRANS_ID_BITS-1:0] req_id;
  logic [WIDTH-1:0]         req_op_a;
  logic [WIDTH-1:0]         req_op_b;
  logic [1:0]               req_opcode;

  logic                     div_vld;
  logic                     div_rdy;
  logic [TRANS_ID_BITS-1:0] div_id;
  logic [WIDTH-1:0]         div_op_a;
  logic [WIDTH-1:0]         div_op_b;
  logic [1:0]               div_opcode;

  logic                     div_out_vld;
  logic                     div_out_rdy;
  logic [TRANS_ID_BITS-1:0] div_res_id;
  logic [WIDTH-1:0]         div_res;

  logic                     wb_valid;
  logic                     wb_ready;
  logic [TRANS_ID_BITS-1:0] wb_id;
  logic [WIDTH-1:0]         wb_result;

  modport slave (
    input  req_valid, req_id, req_op_a, req_op_b, req_opcode,
    output req_ready,
    output div_vld, div_id, div_op_a, div_op_b, div_opcode,
    input  div_rdy,
    input  div_out_vld, div_res_id, div_res,
    output div_out_rdy,
    output wb_valid, wb_id, wb_result,
    input  wb_ready
  );

  modport master (
    output req_valid, req_id, req_op_a, req_op_b, req_opcode,
    input  req_ready,
    input  div_vld, div_id, div_op_a, div_op_b, div_opcode,
    output div_rdy,
    output div_out_vld, div_res_id, div_res,
    input  div_out_rdy,
    input  wb_valid, wb_id, wb_result,
    output wb_ready
  );
endinterface

// File: rtl/serdiv_issue_ctrl.sv
// Serial-divider initiator: request queue, one-op-at-a-time launch FSM and a registered writeback slot.
// Optional SERDIV_ISSUE_FASTZERO_EN retires divide-by-zero ops without visiting the divider.
module serdiv_issue_ctrl #(
  parameter int WIDTH         = 64,
  parameter int DEPTH         = 2,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  serdiv_issue_ctrl_if.slave    bus,
  output logic                  busy_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {IDLE, WAIT_RES} state_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [WIDTH-1:0]         op_a;
    logic [WIDTH-1:0]         op_b;
    logic [1:0]               opcode;
  } entry_t;

  entry_t                   q_mem [DEPTH];
  entry_t                   head;
  logic [PTR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]         count_reg, count_next;
  state_t                   state_reg, state_next;
  logic                     rdy_q_reg;
  logic                     wb_valid_reg, wb_valid_next;
  logic [TRANS_ID_BITS-1:0] wb_id_reg;
  logic [WIDTH-1:0]         wb_result_reg;

  logic empty, req_ready, push, pop, launch, res_hs, out_rdy;
  logic head_zero, fz_pop, load;
  logic [TRANS_ID_BITS-1:0] load_id;
  logic [WIDTH-1:0]         load_result;

  assign head      = q_mem[rd_ptr_reg];
  assign empty     = (count_reg == '0);
  assign req_ready = (count_reg != CNT_W'(DEPTH));
  assign push      = bus.req_valid & req_ready & ~flush_i;
  assign out_rdy   = ~wb_valid_reg | bus.wb_ready;
  assign res_hs    = bus.div_out_vld & out_rdy & ~flush_i;

`ifdef SERDIV_ISSUE_FASTZERO_EN
  // A zero divisor at the head is retired straight into the writeback slot, only from IDLE so order holds.
  assign head_zero = (head.op_b == '0);
  assign fz_pop    = (state_reg == IDLE) & ~empty & head_zero & out_rdy & ~bus.div_out_vld & ~flush_i;
`else
  assign head_zero = 1'b0;
  assign fz_pop    = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        launch = ~empty & ~head_zero & rdy_q_reg & bus.div_rdy & ~flush_i;
        if (launch) state_next = WAIT_RES;
      end
      WAIT_RES: begin
        if (bus.div_out_vld & out_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  assign pop = launch | fz_pop;

  always_comb begin
    count_next = count_reg;
    if (push & ~pop)      count_next = count_reg + 1'b1;
    else if (pop & ~push) count_next = count_reg - 1'b1;
  end

  // Divider results take precedence; the zero-divisor path only ever fires while nothing is in flight.
  assign load        = res_hs | fz_pop;
  assign load_id     = res_hs ? bus.div_res_id : head.id;
  assign load_result = res_hs ? bus.div_res : (head.opcode[1] ? head.op_a : '1);

  always_comb begin
    wb_valid_next = wb_valid_reg;
    if (flush_i)          wb_valid_next = 1'b0;
    else if (load)        wb_valid_next = 1'b1;
    else if (bus.wb_ready) wb_valid_next = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (push) q_mem[wr_ptr_reg] <= '{bus.req_id, bus.req_op_a, bus.req_op_b, bus.req_opcode};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      state_reg     <= IDLE;
      rdy_q_reg     <= 1'b0;
      wb_valid_reg  <= 1'b0;
      wb_id_reg     <= '0;
      wb_result_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wb_valid_reg <= wb_valid_next;
      // rdy_q is dropped on launch so a second launch always waits for a fresh rdy sample.
      rdy_q_reg    <= bus.div_rdy & ~launch & ~flush_i;
      if (flush_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        count_reg <= count_next;
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (load) begin
        wb_id_reg     <= load_id;
        wb_result_reg <= load_result;
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.div_vld     = launch;
  assign bus.div_id      = head.id;
  assign bus.div_op_a    = head.op_a;
  assign bus.div_op_b    = head.op_b;
  assign bus.div_opcode  = head.opcode;
  assign bus.div_out_rdy = out_rdy;
  assign bus.wb_valid    = wb_valid_reg;
  assign bus.wb_id       = wb_id_reg;
  assign bus.wb_result   = wb_result_reg;
  assign busy_o          = ~empty | (state_reg == WAIT_RES) | wb_valid_reg;
endmodule

// File: tb/tb_serdiv_issue_ctrl.sv
// Directed bench for serdiv_issue_ctrl with a behavioural serial divider and an in-order writeback scoreboard.
module tb_serdiv_issue_ctrl;
  localparam int WIDTH = 64;
  localparam int DEPTH = 2;
  localparam int TIB   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;

  serdiv_issue_ctrl_if #(.WIDTH(WIDTH), .TRANS_ID_BITS(TIB)) bus ();

  serdiv_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TRANS_ID_BITS(TIB)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural divider: result div_lat cycles after launch ----------------
  typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} dstate_t;
  int         div_lat = 4;
  logic       div_stall = 1'b0;
  dstate_t    d_state;
  int         d_cnt;
  logic [TIB-1:0]   d_id;
  logic [WIDTH-1:0] d_res, d_a;
  int         launch_cnt;
  int         proto_err;
  logic       prev_rdy, prev_vld;

  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 64'd0) return op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    case (op)
      2'd0: return a / b;
      2'd2: return a % b;
      2'd1: if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return a; else return sa / sb;
      default: if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 64'd0; else return sa % sb;
    endcase
  endfunction

  assign bus.div_rdy     = (d_state == D_IDLE) & ~div_stall;
  assign bus.div_out_vld = (d_state == D_DONE);
  assign bus.div_res_id  = d_id;
  assign bus.div_res     = d_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state <= D_IDLE; d_cnt <= 0; d_id <= '0; d_res <= '0; d_a <= '0;
      launch_cnt <= 0; proto_err <= 0; prev_rdy <= 1'b0; prev_vld <= 1'b0;
    end else begin
      prev_rdy <= bus.div_rdy;
      prev_vld <= bus.div_vld;
      if (bus.div_vld && (!prev_rdy || prev_vld || d_state != D_IDLE)) proto_err <= proto_err + 1;
      if (bus.div_vld) begin
        launch_cnt <= launch_cnt + 1;
        d_a        <= bus.div_op_a;
      end
      if (flush) d_state <= D_IDLE;
      else case (d_state)
        D_IDLE: if (bus.div_vld && bus.div_rdy) begin
          d_id    <= bus.div_id;
          d_res   <= ref_div(bus.div_op_a, bus.div_op_b, bus.div_opcode);
          d_cnt   <= div_lat - 1;
          d_state <= D_BUSY;
        end
        D_BUSY: if (d_cnt <= 1) d_state <= D_DONE; else d_cnt <= d_cnt - 1;
        default: if (bus.div_out_rdy) d_state <= D_IDLE;
      endcase
    end
  end

  // ---------------- scoreboard and checking ----------------
  typedef struct packed {
    logic [TIB-1:0] id;
    logic [63:0]    res;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         wb_cnt = 0;
  int         acc_cyc = 0;
  int         last_wb_cyc = 0;
  logic       accepted = 1'b0;
  logic       last_req_ready = 1'b0;
  logic [63:0] cur_exp = '0;
  logic       hold_pending = 1'b0;
  logic [TIB-1:0] hold_id = '0;
  logic [63:0] hold_res = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (hold_pending) begin
      check("wb_hold_valid", 64'(bus.wb_valid), 64'd1);
      check("wb_hold_id", 64'(bus.wb_id), 64'(hold_id));
      check("wb_hold_result", bus.wb_result, hold_res);
    end
    hold_pending = bus.wb_valid & ~bus.wb_ready & ~flush;
    hold_id      = bus.wb_id;
    hold_res     = bus.wb_result;
    if (bus.wb_valid && bus.wb_ready) begin
      wb_cnt++;
      last_wb_cyc = cyc;
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL wb_unexpected: observed writeback id %0d expected none", bus.wb_id);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        $display("wb  id=%0d result=0x%016h (expected id=%0d 0x%016h)", bus.wb_id, bus.wb_result, e.id, e.res);
        check("wb_id", 64'(bus.wb_id), 64'(e.id));
        check("wb_result", bus.wb_result, e.res);
      end
    end
    last_req_ready = bus.req_ready;
    accepted = bus.req_valid & bus.req_ready & ~flush;
    if (accepted) begin
      sb_q.push_back({bus.req_id, cur_exp});
      acc_cyc = cyc;
      $display("req id=%0d op=%0d a=0x%0h b=0x%0h", bus.req_id, bus.req_opcode, bus.req_op_a, bus.req_op_b);
    end
    if (flush) sb_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [TIB-1:0] id, input logic [63:0] a, input logic [63:0] b,
                           input logic [1:0] op, input logic [63:0] exp);
    bus.req_valid  = 1'b1;
    bus.req_id     = id;
    bus.req_op_a   = a;
    bus.req_op_b   = b;
    bus.req_opcode = op;
    cur_exp        = exp;
  endtask

  task automatic wait_accept(input string tag);
    for (int i = 0; i < 100; i++) begin
      step();
      if (accepted) break;
    end
    check(tag, 64'(accepted), 64'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic issue(input logic [TIB-1:0] id, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] op, input logic [63:0] exp);
    drive_req(id, a, b, op, exp);
    wait_accept("req_accept_timeout");
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy && sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    int base_l, base_w;
    logic third_ok;
    bus.req_valid = 1'b0; bus.req_id = '0; bus.req_op_a = '0; bus.req_op_b = '0; bus.req_opcode = '0;
    bus.wb_ready = 1'b1;

    // reset values
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_div_vld", 64'(bus.div_vld), 64'd0);
    check("rst_div_out_rdy", 64'(bus.div_out_rdy), 64'd1);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_wb_id", 64'(bus.wb_id), 64'd0);
    check("rst_wb_result", bus.wb_result, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step(); step();

    // udiv 100/7, id 3: latency push->wb is 2+D, single pulse, launch carries op_a=100
    base_l = launch_cnt; base_w = wb_cnt;
    issue(3'd3, 64'd100, 64'd7, 2'd0, 64'd14);
    wait_idle("udiv_drain");
    check("udiv_latency", 64'(last_wb_cyc - acc_cyc), 64'(2 + div_lat));
    check("udiv_launch_a", d_a, 64'd100);
    check("udiv_one_launch", 64'(launch_cnt - base_l), 64'd1);
    check("udiv_one_wb", 64'(wb_cnt - base_w), 64'd1);
    check("udiv_wb_low", 64'(bus.wb_valid), 64'd0);

    // signed div then rem of -7 by 2, written in push order
    issue(3'd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'd1, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle("signed_drain");

    // queue full with the divider stalled; third push waits for the first launch
    div_stall = 1'b1;
    step();
    base_l = launch_cnt;
    issue(3'd4, 64'd10, 64'd2, 2'd0, 64'd5);
    issue(3'd5, 64'd20, 64'd4, 2'd0, 64'd5);
    drive_req(3'd6, 64'd21, 64'd5, 2'd2, 64'd1);
    step();
    check("full_ready_low", 64'(last_req_ready), 64'd0);
    check("full_not_accepted", 64'(accepted), 64'd0);
    step();
    check("stall_no_launch", 64'(launch_cnt - base_l), 64'd0);
    div_stall = 1'b0;
    third_ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (accepted) begin
        third_ok = (launch_cnt - base_l) >= 1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    check("third_after_launch", 64'(third_ok), 64'd1);
    wait_idle("full_drain");

    // writeback back-pressure: data holds, divider result held back
    bus.wb_ready = 1'b0;
    issue(3'd7, 64'd50, 64'd5, 2'd0, 64'd10);
    issue(3'd1, 64'd50, 64'd7, 2'd2, 64'd1);
    for (int i = 0; i < 14; i++) step();
    check("bp_wb_valid", 64'(bus.wb_valid), 64'd1);
    check("bp_div_out_rdy", 64'(bus.div_out_rdy), 64'd0);
    check("bp_second_held", 64'(d_state == D_DONE), 64'd1);
    bus.wb_ready = 1'b1;
    wait_idle("bp_drain");

    // flush with one op in flight and one queued
    div_lat = 8;
    base_w = wb_cnt;
    issue(3'd2, 64'd40, 64'd8, 2'd0, 64'd5);
    issue(3'd3, 64'd33, 64'd3, 2'd0, 64'd11);
    step();
    check("pre_flush_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_req_ready", 64'(bus.req_ready), 64'd1);
    check("flush_wb_valid", 64'(bus.wb_valid), 64'd0);
    for (int i = 0; i < 12; i++) step();
    check("flush_no_wb", 64'(wb_cnt - base_w), 64'd0);
    div_lat = 4;
    issue(3'd4, 64'd9, 64'd3, 2'd0, 64'd3);
    wait_idle("post_flush_drain");

    // divide by zero
    base_l = launch_cnt;
    issue(3'd5, 64'd5, 64'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(3'd6, 64'd5, 64'd0, 2'd2, 64'd5);
    wait_idle("zero_drain");
`ifdef SERDIV_ISSUE_FASTZERO_EN
    check("zero_launches", 64'(launch_cnt - base_l), 64'd0);
`else
    check("zero_launches", 64'(launch_cnt - base_l), 64'd2);
`endif

    // asynchronous reset mid-operation
    issue(3'd7, 64'd77, 64'd7, 2'd0, 64'd11);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_req_ready", 64'(bus.req_ready), 64'd1);
    sb_q.delete();
    step();
    rst_n = 1'b1;
    step(); step();
    issue(3'd0, 64'd63, 64'd8, 2'd2, 64'd7);
    wait_idle("post_reset_drain");

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    check("protocol_errors", 64'(proto_err), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
